mac_host_seq: RTL and testbench

- Host-side initiator for the 8-bit signed MAC tile's pin interface.
- Takes a stream of signed (a, b) operand pairs with a last flag and sequences the MAC's load, clear and byte-readback controls.
- Returns the 24-bit dot-product result on a valid/ready output.
- Sits between the system/test controller and the MAC pins (data byte in, control byte in, result byte out).

---
 rtl/mac_if_pkg.sv | 46 ++++
 rtl/mac_host_seq_if.sv | 29 ++
 rtl/mac_host_seq.sv | 127 ++++++++++++
 tb/tb_mac_host_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_if_pkg.sv
// Shared definitions for the MAC tile host sequencer: pin bit positions,
// byte-select codes, datapath widths and the sequencer state encoding.
package mac_if_pkg;

  localparam int OPW  = 8;
  localparam int ACCW = 24;

  // Bit positions on the MAC control pins
  localparam int CTRL_LOAD    = 0;
  localparam int CTRL_SEL_LSB = 1;
  localparam int CTRL_SEL_MSB = 2;
  localparam int CTRL_CLR     = 3;

  // Result byte select codes
  typedef enum logic [1:0] {
    SEL_B0 = 2'd0,
    SEL_B1 = 2'd1,
    SEL_B2 = 2'd2
  } sel_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LD_A,
    ST_LD_B,
    ST_ZA,
    ST_ZB,
    ST_DRAIN,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_DONE
  } state_e;

  // Assemble a control byte; the upper nibble is always zero
  function automatic logic [7:0] ctrl_word(input logic load, input sel_e sel,
                                           input logic clr);
    logic [7:0] w;
    w = '0;
    w[CTRL_LOAD] = load;
    w[CTRL_SEL_MSB:CTRL_SEL_LSB] = sel;
    w[CTRL_CLR] = clr;
    return w;
  endfunction

endpackage

// File: rtl/mac_host_seq_if.sv
// Bundle of the operand stream, result stream and MAC pin signals.
// master = the sequencer, slave = the surrounding controller and MAC tile.
interface mac_host_seq_if;
  import mac_if_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic signed [OPW-1:0]  s_a;
  logic signed [OPW-1:0]  s_b;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [ACCW-1:0]        m_result;
  logic [7:0]             mac_data;
  logic [7:0]             mac_ctrl;
  logic [7:0]             mac_rdata;
  logic                   busy;

  modport master (
    input  s_valid, s_a, s_b, s_last, m_ready, mac_rdata,
    output s_ready, m_valid, m_result, mac_data, mac_ctrl, busy
  );

  modport slave (
    output s_valid, s_a, s_b, s_last, m_ready, mac_rdata,
    input  s_ready, m_valid, m_result, mac_data, mac_ctrl, busy
  );

endinterface

// File: rtl/mac_host_seq.sv
// Host-side sequencer for the 8-bit signed MAC tile. Each accepted pair is
// loaded as a, b, 0, 0 so the product is accumulated once and the MAC operands
// are left at zero; the last pair of a vector triggers a 3-byte readback.
module mac_host_seq
  import mac_if_pkg::*;
#(
  parameter int RD_WAIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  mac_host_seq_if.master bus
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_WAIT);

  state_e                state_q;
  logic                  first_q;
  logic signed [OPW-1:0] a_q;
  logic signed [OPW-1:0] b_q;
  logic                  last_q;
  logic [7:0]            data_q;
  logic [7:0]            ctrl_q;
  logic                  mvalid_q;
  logic [ACCW-1:0]       res_q;
  logic [1:0]            wait_q;

  // Pins are registered: each transition loads the outputs of the state entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      first_q  <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
      mvalid_q <= 1'b0;
      res_q    <= '0;
      wait_q   <= '0;
    end else begin
      ctrl_q <= '0;
      data_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.s_valid) begin
            a_q    <= bus.s_a;
            b_q    <= bus.s_b;
            last_q <= bus.s_last;
            if (first_q) begin
              state_q <= ST_CLEAR;
              ctrl_q  <= ctrl_word(1'b0, SEL_B0, 1'b1);
            end else begin
              state_q <= ST_LD_A;
              ctrl_q  <= ctrl_word(1'b1, SEL_B0, 1'b0);
              data_q  <= bus.s_a;
            end
          end
        end
        ST_CLEAR: begin
          first_q <= 1'b0;
          state_q <= ST_LD_A;
          ctrl_q  <= ctrl_word(1'b1, SEL_B0, 1'b0);
          data_q  <= a_q;
        end
        ST_LD_A: begin
          state_q <= ST_LD_B;
          ctrl_q  <= ctrl_word(1'b1, SEL_B0, 1'b0);
          data_q  <= b_q;
        end
        // Two zero loads flush both operands so the ungated accumulate adds 0
        ST_LD_B: begin
          state_q <= ST_ZA;
          ctrl_q  <= ctrl_word(1'b1, SEL_B0, 1'b0);
        end
        ST_ZA: begin
          state_q <= ST_ZB;
          ctrl_q  <= ctrl_word(1'b1, SEL_B0, 1'b0);
        end
        ST_ZB: begin
          state_q <= last_q ? ST_DRAIN : ST_IDLE;
        end
        // Product of the last pair lands in the accumulator during this cycle
        ST_DRAIN: begin
          state_q <= ST_RD0;
          wait_q  <= '0;
        end
        ST_RD0, ST_RD1, ST_RD2: begin
          if (wait_q == WAIT_LAST) begin
            wait_q <= '0;
            if (state_q == ST_RD0) begin
              res_q[7:0] <= bus.mac_rdata;
              state_q    <= ST_RD1;
              ctrl_q     <= ctrl_word(1'b0, SEL_B1, 1'b0);
            end else if (state_q == ST_RD1) begin
              res_q[15:8] <= bus.mac_rdata;
              state_q     <= ST_RD2;
              ctrl_q      <= ctrl_word(1'b0, SEL_B2, 1'b0);
            end else begin
              res_q[23:16] <= bus.mac_rdata;
              state_q      <= ST_DONE;
              mvalid_q     <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
            ctrl_q <= ctrl_q;
          end
        end
        ST_DONE: begin
          if (bus.m_ready) begin
            mvalid_q <= 1'b0;
            first_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.m_valid  = mvalid_q;
  assign bus.m_result = res_q;
  assign bus.mac_data = data_q;
  assign bus.mac_ctrl = ctrl_q;

endmodule

// File: tb/tb_mac_host_seq.sv
// Bench for mac_host_seq: two instances (RD_WAIT=0 and RD_WAIT=2), each with a
// behavioural MAC tile; expected dot products come from a scoreboard queue.
module tb_mac_host_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_cyc = 0;

  logic [23:0] sb0[$];
  logic [23:0] sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_host_seq_if bus0();
  mac_host_seq_if bus2();

  mac_host_seq #(.RD_WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mac_host_seq #(.RD_WAIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [7:0] pick(input logic [23:0] acc, input logic [1:0] sel);
    case (sel)
      2'd0:    return acc[7:0];
      2'd1:    return acc[15:8];
      2'd2:    return acc[23:16];
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural MAC tile 0: alternating operand loads, registered product, ungated accumulate
  logic signed [7:0]  opa0, opb0, opa2, opb2;
  logic               par0, par2;
  logic signed [15:0] prod0, prod2;
  logic [23:0]        acc0, acc2;
  logic [7:0]         rd2a, rd2b;
  int                 ld_cnt0 = 0;
  int                 clr_cnt0 = 0;

  always @(posedge clk) begin
    if (rst) begin
      opa0 <= '0; opb0 <= '0; par0 <= 1'b0; prod0 <= '0; acc0 <= '0;
    end else begin
      if (bus0.mac_ctrl[0]) begin
        if (!par0) opa0 <= bus0.mac_data;
        else       opb0 <= bus0.mac_data;
        par0    <= ~par0;
        ld_cnt0 <= ld_cnt0 + 1;
      end
      if (bus0.mac_ctrl[3]) clr_cnt0 <= clr_cnt0 + 1;
      prod0 <= opa0 * opb0;
      acc0  <= bus0.mac_ctrl[3] ? 24'd0 : acc0 + {{8{prod0[15]}}, prod0};
    end
  end
  assign bus0.mac_rdata = pick(acc0, bus0.mac_ctrl[2:1]);

  // Behavioural MAC tile 2 with a two-cycle delay on the result byte pins
  always @(posedge clk) begin
    if (rst) begin
      opa2 <= '0; opb2 <= '0; par2 <= 1'b0; prod2 <= '0; acc2 <= '0;
    end else begin
      if (bus2.mac_ctrl[0]) begin
        if (!par2) opa2 <= bus2.mac_data;
        else       opb2 <= bus2.mac_data;
        par2 <= ~par2;
      end
      prod2 <= opa2 * opb2;
      acc2  <= bus2.mac_ctrl[3] ? 24'd0 : acc2 + {{8{prod2[15]}}, prod2};
    end
    rd2a <= pick(acc2, bus2.mac_ctrl[2:1]);
    rd2b <= rd2a;
  end
  assign bus2.mac_rdata = rd2b;

  // Present one pair and wait for its handshake; called #1 after an edge
  task automatic send(input bit u2, input logic [7:0] a, input logic [7:0] b, input logic last);
    int  n;
    logic rdy;
    n = 0;
    if (u2) begin bus2.s_a = a; bus2.s_b = b; bus2.s_last = last; bus2.s_valid = 1'b1; end
    else    begin bus0.s_a = a; bus0.s_b = b; bus0.s_last = last; bus0.s_valid = 1'b1; end
    rdy = u2 ? bus2.s_ready : bus0.s_ready;
    while (!rdy && n < 60) begin
      @(posedge clk); #1;
      n++;
      rdy = u2 ? bus2.s_ready : bus0.s_ready;
    end
    if (!rdy) begin
      errors++; checks++;
      $display("FAIL send_timeout s_ready=%b required 1", rdy);
    end else begin
      @(posedge clk); #1;
      hs_cyc = cyc;
    end
    bus0.s_valid = 1'b0;
    bus2.s_valid = 1'b0;
  endtask

  // Accept the next result; vcyc records the edge count when m_valid was seen
  task automatic get_result(input bit u2, output logic [23:0] r, output int vcyc);
    int   n;
    logic v;
    n = 0; r = '0; vcyc = 0;
    if (u2) bus2.m_ready = 1'b1; else bus0.m_ready = 1'b1;
    v = u2 ? bus2.m_valid : bus0.m_valid;
    while (!v && n < 100) begin
      @(posedge clk); #1;
      n++;
      v = u2 ? bus2.m_valid : bus0.m_valid;
    end
    if (!v) begin
      errors++; checks++;
      $display("FAIL result_timeout m_valid=%b required 1", v);
    end else begin
      vcyc = cyc;
      r = u2 ? bus2.m_result : bus0.m_result;
      @(posedge clk); #1;
    end
    bus0.m_ready = 1'b0;
    bus2.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [43:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus0.s_ready, bus0.m_valid, bus0.busy, bus0.mac_ctrl, bus0.mac_data, bus0.m_result};
    checks++;
    if (got !== 44'd0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", got);
    end
    checks++;
    if (bus2.s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready2 got %b required 0", bus2.s_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus0.s_ready, bus2.s_ready, bus0.busy} !== 3'b110) begin
      errors++; $display("FAIL post_reset_ready got %b required 110",
                         {bus0.s_ready, bus2.s_ready, bus0.busy});
    end
  endtask

  task automatic test_two_pair();
    int sum, ld_base, clr_base, vc;
    logic [23:0] r, exp;
    sum = 3 * 4 + (-2) * 5;
    sb0.push_back(sum[23:0]);
    ld_base = ld_cnt0; clr_base = clr_cnt0;
    send(1'b0, 8'd3, 8'd4, 1'b0);
    send(1'b0, 8'hFE, 8'd5, 1'b1);
    get_result(1'b0, r, vc);
    exp = sb0.pop_front();
    checks++;
    if (r !== exp) begin errors++; $display("FAIL two_pair_result got %h required %h", r, exp); end
    checks++;
    if (ld_cnt0 - ld_base !== 8) begin
      errors++; $display("FAIL two_pair_loads got %0d required 8", ld_cnt0 - ld_base);
    end
    checks++;
    if (clr_cnt0 - clr_base !== 1) begin
      errors++; $display("FAIL two_pair_clears got %0d required 1", clr_cnt0 - clr_base);
    end
  endtask

  task automatic test_single_latency();
    int vc;
    logic [23:0] r, exp;
    sb0.push_back(24'h004000);
    send(1'b0, 8'h80, 8'h80, 1'b1);
    get_result(1'b0, r, vc);
    exp = sb0.pop_front();
    checks++;
    if (r !== exp) begin errors++; $display("FAIL single_result got %h required %h", r, exp); end
    checks++;
    if (vc - hs_cyc !== 9) begin
      errors++; $display("FAIL single_latency got %0d edges required 9", vc - hs_cyc);
    end
  endtask

  task automatic test_wrap512();
    int sum, vc;
    logic [23:0] r, exp;
    sum = 0;
    for (int i = 0; i < 512; i++) sum += (-128) * (-128);
    sb0.push_back(sum[23:0]);
    for (int i = 0; i < 512; i++) begin
      send(1'b0, 8'h80, 8'h80, (i == 511));
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (par0 !== 1'b0) begin
        errors++; $display("FAIL wrap_parity pair %0d got %b required 0 (A)", i, par0);
      end
    end
    get_result(1'b0, r, vc);
    exp = sb0.pop_front();
    checks++;
    if (r !== exp) begin errors++; $display("FAIL wrap_result got %h required %h", r, exp); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [23:0] exp;
    sb0.push_back(24'd30);
    send(1'b0, 8'd5, 8'd6, 1'b1);
    n = 0;
    while (!bus0.m_valid && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus0.m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid_timeout got %b required 1", bus0.m_valid);
    end
    exp = sb0[0];
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus0.m_valid, bus0.m_result, bus0.s_ready} !== {1'b1, exp, 1'b0}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b r=%h rdy=%b required v=1 r=%h rdy=0",
                           i, bus0.m_valid, bus0.m_result, bus0.s_ready, exp);
      end
      @(posedge clk); #1;
    end
    bus0.m_ready = 1'b1;
    @(posedge clk); #1;
    bus0.m_ready = 1'b0;
    void'(sb0.pop_front());
    checks++;
    if ({bus0.m_valid, bus0.busy, bus0.s_ready} !== 3'b001) begin
      errors++; $display("FAIL bp_accept got v/busy/rdy=%b required 001",
                         {bus0.m_valid, bus0.busy, bus0.s_ready});
    end
  endtask

  task automatic test_reset_midread();
    int n, vc;
    logic [43:0] got;
    logic [23:0] r, exp;
    sb0.push_back(24'd60);
    send(1'b0, 8'd20, 8'd3, 1'b1);
    n = 0;
    while (bus0.mac_ctrl[2:1] !== 2'd1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus0.mac_ctrl[2:1] !== 2'd1) begin
      errors++; $display("FAIL rd1_timeout sel got %0d required 1", bus0.mac_ctrl[2:1]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    got = {bus0.s_ready, bus0.m_valid, bus0.busy, bus0.mac_ctrl, bus0.mac_data, bus0.m_result};
    checks++;
    if (got !== 44'd0) begin errors++; $display("FAIL midread_reset got %h required 0", got); end
    sb0.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus0.s_ready !== 1'b1) begin
      errors++; $display("FAIL midread_ready got %b required 1", bus0.s_ready);
    end
    sb0.push_back(24'hFFFFF9);
    send(1'b0, 8'd7, 8'hFF, 1'b1);
    get_result(1'b0, r, vc);
    exp = sb0.pop_front();
    checks++;
    if (r !== exp) begin errors++; $display("FAIL midread_result got %h required %h", r, exp); end
  endtask

  task automatic test_rd_wait();
    int n;
    int cnt[3];
    logic [23:0] r, exp;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    sb2.push_back(24'd100);
    send(1'b1, 8'd10, 8'd10, 1'b1);
    bus2.m_ready = 1'b1;
    n = 0;
    while (!bus2.m_valid && n < 60) begin
      // Select-only cycles: DRAIN shows select 0 too, so byte 0 counts one extra
      if (bus2.busy && !bus2.mac_ctrl[0] && !bus2.mac_ctrl[3] && bus2.mac_ctrl[2:1] != 2'd3)
        cnt[bus2.mac_ctrl[2:1]]++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus2.m_valid !== 1'b1) begin
      errors++; $display("FAIL rdw_timeout m_valid got %b required 1", bus2.m_valid);
    end
    r = bus2.m_result;
    @(posedge clk); #1;
    bus2.m_ready = 1'b0;
    exp = sb2.pop_front();
    checks++;
    if (r !== exp) begin errors++; $display("FAIL rdw_result got %h required %h", r, exp); end
    checks++;
    if ({cnt[0], cnt[1], cnt[2]} !== {32'd4, 32'd3, 32'd3}) begin
      errors++; $display("FAIL rdw_sel_hold got %0d/%0d/%0d required 4/3/3", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  initial begin
    bus0.s_valid = 1'b0; bus0.s_a = '0; bus0.s_b = '0; bus0.s_last = 1'b0; bus0.m_ready = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_a = '0; bus2.s_b = '0; bus2.s_last = 1'b0; bus2.m_ready = 1'b0;
    test_reset();
    test_two_pair();
    test_single_latency();
    test_wrap512();
    test_backpressure();
    test_reset_midread();
    test_rd_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
